// File: rtl/writeback_queue_if.sv
// Bundle for the writeback queue: producer results, register-file write port,
// and the decode-side forwarding lookup.
interface writeback_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rs_a;
  logic [ADDR_W-1:0] rs_b;
  logic              hit_a;
  logic [DATA_W-1:0] fwd_a;
  logic              hit_b;
  logic [DATA_W-1:0] fwd_b;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs_a, rs_b,
    input  full, count, overflow, wb_write, wb_reg, wb_data, hit_a, fwd_a, hit_b, fwd_b
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs_a, rs_b,
    output full, count, overflow, wb_write, wb_reg, wb_data, hit_a, fwd_a, hit_b, fwd_b
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order FIFO of ALU/load results feeding the register file write port, with
// youngest-wins forwarding of every pending write to the decode read indices.
module writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input logic              clock,
  input logic              reset,
  writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = PTR_W + 1;

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  mem_slot;
  logic [PTR_W-1:0]  tail_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  slots;
  logic              overflow;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              pop;
  logic              alu_want;
  logic              mem_want;
  logic              alu_acc;
  logic              mem_acc;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [SUM_W-1:0]  pos;
  logic [PTR_W-1:0]  idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A draining head frees its slot for the same edge; the ALU entry claims first.
  always_comb begin
    pop       = (count != '0);
    alu_want  = bus.alu_valid && (bus.alu_reg != '0);
    mem_want  = bus.mem_valid && (bus.mem_reg != '0);
    slots     = CNT_W'(DEPTH) - count + CNT_W'(pop);
    alu_acc   = alu_want && (slots != '0);
    mem_acc   = mem_want && (slots > CNT_W'(alu_acc));
    mem_slot  = alu_acc ? ptr_inc(tail) : tail;
    tail_next = mem_acc ? ptr_inc(mem_slot) : mem_slot;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wb_write <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
    end else begin
      if (pop) begin
        wb_write <= 1'b1;
        wb_reg   <= reg_q[head];
        wb_data  <= data_q[head];
        head     <= ptr_inc(head);
      end else begin
        wb_write <= 1'b0;
      end
      tail  <= tail_next;
      count <= count + CNT_W'(alu_acc) + CNT_W'(mem_acc) - CNT_W'(pop);
      if ((alu_want && !alu_acc) || (mem_want && !mem_acc)) overflow <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity is tracked by head/count.
  always_ff @(posedge clock) begin
    if (alu_acc) begin
      reg_q[tail]  <= bus.alu_reg;
      data_q[tail] <= bus.alu_data;
    end
    if (mem_acc) begin
      reg_q[mem_slot]  <= bus.mem_reg;
      data_q[mem_slot] <= bus.mem_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; wb_* is oldest.
  always_comb begin
    hit_a = 1'b0;
    fwd_a = '0;
    hit_b = 1'b0;
    fwd_b = '0;
    pos   = '0;
    idx   = '0;
    if (wb_write && (bus.rs_a != '0) && (wb_reg == bus.rs_a)) begin
      hit_a = 1'b1;
      fwd_a = wb_data;
    end
    if (wb_write && (bus.rs_b != '0) && (wb_reg == bus.rs_b)) begin
      hit_b = 1'b1;
      fwd_b = wb_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      pos = SUM_W'(head) + SUM_W'(i);
      if (pos >= SUM_W'(DEPTH)) pos = pos - SUM_W'(DEPTH);
      idx = pos[PTR_W-1:0];
      if (CNT_W'(i) < count) begin
        if ((bus.rs_a != '0) && (reg_q[idx] == bus.rs_a)) begin
          hit_a = 1'b1;
          fwd_a = data_q[idx];
        end
        if ((bus.rs_b != '0) && (reg_q[idx] == bus.rs_b)) begin
          hit_b = 1'b1;
          fwd_b = data_q[idx];
        end
      end
    end
  end

  assign bus.full     = (CNT_W'(DEPTH) - count) < CNT_W'(2);
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.wb_write = wb_write;
  assign bus.wb_reg   = wb_reg;
  assign bus.wb_data  = wb_data;
  assign bus.hit_a    = hit_a;
  assign bus.fwd_a    = fwd_a;
  assign bus.hit_b    = hit_b;
  assign bus.fwd_b    = fwd_b;
endmodule

// File: tb/tb_writeback_queue.sv
// Scenario bench for writeback_queue: issued entries go to a scoreboard queue,
// and a monitor pops and compares them whenever the write port fires.
module tb_writeback_queue;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [ADDR_W+DATA_W-1:0] ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   m_count = 0;
  bit   m_ovf = 1'b0;
  ent_t sb[$];

  writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    ent_t exp_e;
    if (!reset && bus.wb_write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected got reg=%0d data=%h expected no write", bus.wb_reg, bus.wb_data);
      end else begin
        exp_e = sb.pop_front();
        if ({bus.wb_reg, bus.wb_data} !== exp_e)
          $display("FAIL wb_order got reg=%0d data=%h expected reg=%0d data=%h",
                   bus.wb_reg, bus.wb_data, exp_e[ADDR_W+DATA_W-1:DATA_W], exp_e[DATA_W-1:0]);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit av, input int ar, input int ad, input bit mv, input int mr, input int md);
    int slots;
    int acc;
    int popn;
    bus.alu_valid = av;
    bus.alu_reg   = ADDR_W'(ar);
    bus.alu_data  = DATA_W'(ad);
    bus.mem_valid = mv;
    bus.mem_reg   = ADDR_W'(mr);
    bus.mem_data  = DATA_W'(md);
    acc   = 0;
    popn  = (m_count > 0) ? 1 : 0;
    slots = DEPTH - m_count + popn;
    if (av && ar != 0) begin
      if (slots > 0) begin sb.push_back({ADDR_W'(ar), DATA_W'(ad)}); slots--; acc++; end
      else m_ovf = 1'b1;
    end
    if (mv && mr != 0) begin
      if (slots > 0) begin sb.push_back({ADDR_W'(mr), DATA_W'(md)}); slots--; acc++; end
      else m_ovf = 1'b1;
    end
    m_count = m_count + acc - popn;
  endtask

  task automatic step(input bit av, input int ar, input int ad, input bit mv, input int mr, input int md);
    issue(av, ar, ad, mv, mr, md);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.alu_valid = 0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.rs_a = '0; bus.rs_b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d expected 0", bus.count); else passed++;
    checks++; if (bus.full !== 1'b0) $display("FAIL reset_full got %0b expected 0", bus.full); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %0b expected 0", bus.overflow); else passed++;
    checks++; if (bus.wb_write !== 1'b0) $display("FAIL reset_wb_write got %0b expected 0", bus.wb_write); else passed++;
    checks++; if ({bus.wb_reg, bus.wb_data} !== '0) $display("FAIL reset_wb_regdata got %0d/%h expected 0/0", bus.wb_reg, bus.wb_data); else passed++;
    reset = 1'b0;
    m_count = 0;
    m_ovf = 1'b0;
  endtask

  task automatic test_single();
    step(1, 4, 'h0002, 0, 0, 0);
    checks++; if (bus.count !== 3'd1) $display("FAIL single_count got %0d expected 1", bus.count); else passed++;
    checks++; if (bus.wb_write !== 1'b0) $display("FAIL single_early got %0b expected 0", bus.wb_write); else passed++;
    idle();
    checks++; if (bus.wb_write !== 1'b1) $display("FAIL single_write got %0b expected 1", bus.wb_write); else passed++;
    checks++; if (bus.wb_reg !== 5'd4 || bus.wb_data !== 16'h0002)
      $display("FAIL single_data got %0d/%h expected 4/0002", bus.wb_reg, bus.wb_data); else passed++;
    idle();
    checks++; if (bus.wb_write !== 1'b0) $display("FAIL single_drop got %0b expected 0", bus.wb_write); else passed++;
    checks++; if (bus.wb_reg !== 5'd4 || bus.wb_data !== 16'h0002)
      $display("FAIL single_hold got %0d/%h expected 4/0002", bus.wb_reg, bus.wb_data); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL single_drained got %0d expected 0", sb.size()); else passed++;
  endtask

  task automatic test_dual();
    step(1, 6, 5, 1, 1, 3);
    checks++; if (bus.count !== 3'd2) $display("FAIL dual_count2 got %0d expected 2", bus.count); else passed++;
    idle();
    checks++; if (bus.count !== 3'd1) $display("FAIL dual_count1 got %0d expected 1", bus.count); else passed++;
    checks++; if (bus.wb_write !== 1'b1 || bus.wb_reg !== 5'd6 || bus.wb_data !== 16'd5)
      $display("FAIL dual_first got %0b %0d/%0d expected 1 6/5", bus.wb_write, bus.wb_reg, bus.wb_data); else passed++;
    idle();
    checks++; if (bus.count !== 3'd0) $display("FAIL dual_count0 got %0d expected 0", bus.count); else passed++;
    checks++; if (bus.wb_write !== 1'b1 || bus.wb_reg !== 5'd1 || bus.wb_data !== 16'd3)
      $display("FAIL dual_second got %0b %0d/%0d expected 1 1/3", bus.wb_write, bus.wb_reg, bus.wb_data); else passed++;
    idle();
    checks++; if (bus.wb_write !== 1'b0) $display("FAIL dual_idle got %0b expected 0", bus.wb_write); else passed++;
  endtask

  task automatic test_r0();
    step(1, 0, 3, 0, 0, 0);
    checks++; if (bus.count !== 3'd0) $display("FAIL r0_count got %0d expected 0", bus.count); else passed++;
    checks++; if (bus.wb_write !== 1'b0) $display("FAIL r0_write got %0b expected 0", bus.wb_write); else passed++;
    bus.rs_a = '0;
    #1;
    checks++; if (bus.hit_a !== 1'b0 || bus.fwd_a !== 16'd0)
      $display("FAIL r0_fwd got %0b/%h expected 0/0000", bus.hit_a, bus.fwd_a); else passed++;
    step(1, 5, 'h55, 1, 0, 'h66);
    checks++; if (bus.count !== 3'd1) $display("FAIL r0_mixed_count got %0d expected 1", bus.count); else passed++;
    idle();
    idle();
    checks++; if (bus.overflow !== 1'b0) $display("FAIL r0_no_overflow got %0b expected 0", bus.overflow); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL r0_drained got %0d expected 0", sb.size()); else passed++;
  endtask

  task automatic test_forward();
    step(1, 4, 2, 0, 0, 0);
    bus.rs_a = 5'd4;
    bus.rs_b = 5'd9;
    #1;
    checks++; if (bus.hit_a !== 1'b1 || bus.fwd_a !== 16'd2)
      $display("FAIL fwd_queued got %0b/%0d expected 1/2", bus.hit_a, bus.fwd_a); else passed++;
    checks++; if (bus.hit_b !== 1'b0 || bus.fwd_b !== 16'd0)
      $display("FAIL fwd_miss got %0b/%0d expected 0/0", bus.hit_b, bus.fwd_b); else passed++;
    step(1, 4, 7, 0, 0, 0);
    checks++; if (bus.hit_a !== 1'b1 || bus.fwd_a !== 16'd7)
      $display("FAIL fwd_younger got %0b/%0d expected 1/7", bus.hit_a, bus.fwd_a); else passed++;
    idle();
    checks++; if (bus.hit_a !== 1'b1 || bus.fwd_a !== 16'd7)
      $display("FAIL fwd_wb got %0b/%0d expected 1/7", bus.hit_a, bus.fwd_a); else passed++;
    idle();
    checks++; if (bus.hit_a !== 1'b0 || bus.fwd_a !== 16'd0)
      $display("FAIL fwd_retired got %0b/%0d expected 0/0", bus.hit_a, bus.fwd_a); else passed++;
    step(1, 9, 1, 1, 9, 8);
    checks++; if (bus.hit_b !== 1'b1 || bus.fwd_b !== 16'd8)
      $display("FAIL fwd_same_cycle got %0b/%0d expected 1/8", bus.hit_b, bus.fwd_b); else passed++;
    idle();
    checks++; if (bus.hit_b !== 1'b1 || bus.fwd_b !== 16'd8)
      $display("FAIL fwd_fifo_over_wb got %0b/%0d expected 1/8", bus.hit_b, bus.fwd_b); else passed++;
    idle();
    idle();
    checks++; if (bus.hit_b !== 1'b0) $display("FAIL fwd_b_retired got %0b expected 0", bus.hit_b); else passed++;
    bus.rs_a = '0;
    bus.rs_b = '0;
  endtask

  task automatic test_overflow();
    int exp_cnt [5];
    bit exp_ovf [5];
    exp_cnt = '{2, 3, 4, 4, 4};
    exp_ovf = '{0, 0, 0, 1, 1};
    for (int k = 0; k < 5; k++) begin
      step(1, 10 + 2 * k, 'h100 + k, 1, 11 + 2 * k, 'h200 + k);
      checks++; if (bus.count !== CNT_W'(exp_cnt[k]))
        $display("FAIL ovf_count%0d got %0d expected %0d", k, bus.count, exp_cnt[k]); else passed++;
      checks++; if (bus.full !== ((DEPTH - exp_cnt[k]) < 2))
        $display("FAIL ovf_full%0d got %0b expected %0b", k, bus.full, (DEPTH - exp_cnt[k]) < 2); else passed++;
      checks++; if (bus.overflow !== exp_ovf[k])
        $display("FAIL ovf_flag%0d got %0b expected %0b", k, bus.overflow, exp_ovf[k]); else passed++;
    end
    for (int n = 0; n < 20 && m_count > 0; n++) begin
      idle();
      checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got %0b expected 1", bus.overflow); else passed++;
    end
    idle();
    checks++; if (bus.wb_write !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL ovf_empty got %0b/%0d expected 0/0", bus.wb_write, bus.count); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL ovf_drained got %0d expected 0", sb.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    step(1, 2, 'h21, 1, 3, 'h31);
    step(1, 5, 'h51, 1, 7, 'h71);
    checks++; if (bus.count !== 3'd3) $display("FAIL rstmid_pre got %0d expected 3", bus.count); else passed++;
    bus.alu_valid = 0;
    bus.mem_valid = 0;
    reset = 1'b1;
    #1;
    checks++; if (bus.count !== 3'd0) $display("FAIL rstmid_count got %0d expected 0", bus.count); else passed++;
    checks++; if (bus.wb_write !== 1'b0) $display("FAIL rstmid_write got %0b expected 0", bus.wb_write); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL rstmid_overflow got %0b expected 0", bus.overflow); else passed++;
    sb.delete();
    m_count = 0;
    m_ovf = 1'b0;
    reset = 1'b0;
    idle();
    checks++; if (bus.wb_write !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL rstmid_after got %0b/%0d expected 0/0", bus.wb_write, bus.count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_r0();
    test_forward();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
